fft16_unloader: RTL
===================

FFT16_UNLOADER -- requirements
Module: fft16_unloader

Interface
REQ-001 Parameter DATA_WIDTH, default 20: bit width of each real and imag sample.
REQ-002 Parameter BIT_REVERSE, default 0: 1 = emit stored lanes in 4-bit bit-reversed order; 0 = natural order.
REQ-003 clk  in  1: single clock; all state on rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset.
REQ-005 frame_in_valid  in  1: a complete 16-point frame is present on the flat buses.
REQ-006 frame_in_ready  out  1: unloader accepts the frame this cycle.
REQ-007 x_in_flat_real  in  DATA_WIDTH*16: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 x_in_flat_imag  in  DATA_WIDTH*16: same lane packing as real.
REQ-009 out_valid  out  1: a sample is presented on the stream.
REQ-010 out_ready  in  1: downstream accepts the presented sample.
REQ-011 out_real  out  DATA_WIDTH: real part of the presented sample.
REQ-012 out_imag  out  DATA_WIDTH: imag part of the presented sample.
REQ-013 out_index  out  4: bin number of the presented sample (the stored lane number).
REQ-014 out_last  out  1: high with the 16th sample of a frame.

Function
REQ-015 The block SHALL hold two frame banks (ping-pong), each 16 x (real, imag), plus per-bank full flags, a write-bank pointer wr, a read-bank pointer rd and a 4-bit sample counter cnt.
REQ-016 frame_in_ready SHALL equal NOT full[wr], driven from registers only, with no combinational path from out_ready or frame_in_valid.
REQ-017 On frame_in_valid AND frame_in_ready, the block SHALL capture all 32 lanes into bank[wr], set full[wr] and toggle wr at that edge.
REQ-018 out_valid SHALL equal full[rd]; the first sample of a captured frame is presented the cycle after capture (latency 1).
REQ-019 The presented lane L SHALL be cnt when BIT_REVERSE=0 and bitrev4(cnt) when BIT_REVERSE=1; out_index=L, out_real/out_imag=bank[rd] lane L, and out_last=(cnt==15).
REQ-020 A transfer occurs on out_valid AND out_ready; on a transfer cnt increments; on a transfer with cnt==15, cnt wraps to 0, full[rd] clears and rd toggles.
REQ-021 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-022 When out_valid=0, out_real/out_imag/out_index/out_last SHALL be 0.
REQ-023 Simultaneous capture into bank[wr] and last-sample release of bank[rd] (different banks) SHALL both take effect in the same cycle.
REQ-024 When both banks are full, frame_in_ready=0; a bank freed at edge N makes frame_in_ready=1 in cycle N+1, not in cycle N.
REQ-025 Sustained throughput SHALL be 16 samples per 16 cycles with out_ready held high and frames offered back-to-back, with no bubbles between frames.
REQ-026 Stored data SHALL be passed bit-exact, with no arithmetic, rounding or sign change.

Reset
REQ-027 Asserting reset low SHALL immediately clear full[0], full[1], wr, rd and cnt, forcing out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0 and frame_in_ready=1.
REQ-028 Bank contents need not be reset; a frame in progress at reset is discarded.
REQ-029 Release of reset SHALL be sampled synchronously to clk by the integrating system; the block takes no action other than resuming from the cleared state.

Structure
REQ-030 A shared package SHALL hold FFT_POINTS=16, FFT_IDX_W=4, the DATA_WIDTH default of 20, and the bitrev4 function.
REQ-031 One sub-module, fft16_frame_bank (16-lane register bank with write-all and 4-bit read select), SHALL be instantiated twice.

Verification
REQ-032 Single frame: after reset, frame lanes real=i and imag=-i, out_ready=1 -> 16 consecutive samples with out_index 0..15, out_real 0..15, out_imag 0,-1..-15 and out_last only on index 15, with the first sample in the cycle after capture.
REQ-033 Backpressure: toggle out_ready 1,0,0,1,... on the same frame -> out_* held stable during stalls, with no sample lost or duplicated.
REQ-034 Ping-pong full: offer frames A, B and C back-to-back with out_ready=0 -> A and B accepted and frame_in_ready=0 for C; after A's 16th transfer, C is accepted the following cycle and the output order is A, B, C.
REQ-035 Back-to-back streaming: 4 frames with out_ready=1 -> 64 contiguous out_valid cycles and out_last every 16th.
REQ-036 BIT_REVERSE=1 with real=i -> out_index sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with out_real equal to out_index.
REQ-037 Reset mid-frame: assert reset after the 5th transfer of a frame -> out_valid=0 and frame_in_ready=1 immediately; the next frame streams from index 0.

Source files
------------

// File: rtl/fft16_unloader_pkg.sv
// Shared constants and helpers for the 16-point FFT frame unloader.
// Bin indices are 4 bits; bitrev4 maps a natural-order count to bit-reversed lane order.
package fft16_unloader_pkg;

  localparam int FFT_POINTS     = 16;
  localparam int FFT_IDX_W      = 4;
  localparam int DATA_WIDTH_DEF = 20;

  function automatic logic [FFT_IDX_W-1:0] bitrev4(input logic [FFT_IDX_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-lane (real, imag) frame store: write-all in one cycle, 4-bit indexed read.
// Write takes effect at the clock edge; read is combinational from the stored lanes.
module fft16_frame_bank
  import fft16_unloader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             i_we,
  input  logic [DATA_WIDTH*FFT_POINTS-1:0] i_real_flat,
  input  logic [DATA_WIDTH*FFT_POINTS-1:0] i_imag_flat,
  input  logic [FFT_IDX_W-1:0]             i_sel,
  output logic [DATA_WIDTH-1:0]            o_real,
  output logic [DATA_WIDTH-1:0]            o_imag
);

  logic [DATA_WIDTH-1:0] r_real [FFT_POINTS];
  logic [DATA_WIDTH-1:0] r_imag [FFT_POINTS];

  // Contents are deliberately not reset; the owning full flag says whether they mean anything.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        r_real[i] <= i_real_flat[i*DATA_WIDTH +: DATA_WIDTH];
        r_imag[i] <= i_imag_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_real = r_real[i_sel];
  assign o_imag = r_imag[i_sel];

endmodule

// File: rtl/fft16_unloader.sv
// Ping-pong frame unloader: accepts a whole 16-point frame, streams it out one bin per transfer.
// First sample appears the cycle after capture; out_ready stalls hold the stream, full banks stall input.
module fft16_unloader
  import fft16_unloader_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BIT_REVERSE = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_in_valid,
  output logic                             frame_in_ready,
  input  logic [DATA_WIDTH*FFT_POINTS-1:0] x_in_flat_real,
  input  logic [DATA_WIDTH*FFT_POINTS-1:0] x_in_flat_imag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_real,
  output logic [DATA_WIDTH-1:0]            out_imag,
  output logic [FFT_IDX_W-1:0]             out_index,
  output logic                             out_last
);

  logic [1:0]            r_full;
  logic                  r_wr;
  logic                  r_rd;
  logic [FFT_IDX_W-1:0]  r_cnt;

  logic                  w_cap;
  logic                  w_xfer;
  logic                  w_rel;
  logic [1:0]            w_we;
  logic [1:0]            w_clr;
  logic [FFT_IDX_W-1:0]  w_lane;
  logic [DATA_WIDTH-1:0] w_real0;
  logic [DATA_WIDTH-1:0] w_imag0;
  logic [DATA_WIDTH-1:0] w_real1;
  logic [DATA_WIDTH-1:0] w_imag1;

  // Ready comes straight from flags so no input-to-ready combinational path exists.
  assign frame_in_ready = ~r_full[r_wr];
  assign out_valid      = r_full[r_rd];

  assign w_cap  = frame_in_valid & frame_in_ready;
  assign w_xfer = out_valid & out_ready;
  assign w_rel  = w_xfer & (r_cnt == FFT_IDX_W'(FFT_POINTS - 1));
  assign w_we   = {w_cap & r_wr, w_cap & ~r_wr};
  assign w_clr  = {w_rel & r_rd, w_rel & ~r_rd};
  assign w_lane = (BIT_REVERSE != 0) ? bitrev4(r_cnt) : r_cnt;

  fft16_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clk         (clk),
    .i_we        (w_we[0]),
    .i_real_flat (x_in_flat_real),
    .i_imag_flat (x_in_flat_imag),
    .i_sel       (w_lane),
    .o_real      (w_real0),
    .o_imag      (w_imag0)
  );

  fft16_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clk         (clk),
    .i_we        (w_we[1]),
    .i_real_flat (x_in_flat_real),
    .i_imag_flat (x_in_flat_imag),
    .i_sel       (w_lane),
    .o_real      (w_real1),
    .o_imag      (w_imag1)
  );

  // Capture only targets an empty bank and release only a full one, so set and clear never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 2'b00;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_full <= (r_full | w_we) & ~w_clr;
      if (w_cap)  r_wr  <= ~r_wr;
      if (w_rel)  r_rd  <= ~r_rd;
      if (w_xfer) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    out_real  = '0;
    out_imag  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_real  = r_rd ? w_real1 : w_real0;
      out_imag  = r_rd ? w_imag1 : w_imag0;
      out_index = w_lane;
      out_last  = (r_cnt == FFT_IDX_W'(FFT_POINTS - 1));
    end
  end

endmodule
